// File: rtl/s_term_uio_bot_serdes.sv
// s_term_uio_bot_serdes: serialises UIO_BOT_FIN onto LANES framed pad pins and
// deserialises the inbound lanes back into UIO_BOT_FOUT for the south-terminal switch matrix.
module s_term_uio_bot_serdes #(
    parameter int WIDTH = 20,
    parameter int LANES = 4,
    parameter int SYNC  = 2
) (
    input  logic             UserCLK,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] UIO_BOT_FIN,
    output logic [WIDTH-1:0] UIO_BOT_FOUT,
    output logic [LANES-1:0] tx_data,
    output logic             tx_frame,
    output logic             tx_oe,
    input  logic [LANES-1:0] rx_data,
    input  logic             rx_frame,
    output logic             rx_valid,
    output logic             rx_locked,
    output logic [7:0]       err_count
);
    localparam int BEATS = (WIDTH + LANES - 1) / LANES;
    localparam int PW    = BEATS * LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    typedef enum logic {TX_IDLE, TX_RUN} tx_state_t;
    typedef enum logic {RX_HUNT, RX_LOCK} rx_state_t;

    tx_state_t        tx_state, tx_state_nxt;
    logic [BW-1:0]    tx_beat, tx_beat_nxt;
    logic [PW-1:0]    shadow, shadow_nxt, fin_pad;
    logic [LANES-1:0] tx_data_nxt;
    logic             tx_frame_nxt;

    assign fin_pad = PW'(UIO_BOT_FIN);
    assign tx_oe   = (tx_state == TX_RUN);

    always_ff @(posedge UserCLK or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_beat  <= '0;
            shadow   <= '0;
            tx_data  <= '0;
            tx_frame <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_beat  <= tx_beat_nxt;
            shadow   <= shadow_nxt;
            tx_data  <= tx_data_nxt;
            tx_frame <= tx_frame_nxt;
        end
    end

    // Dropping enable at any beat abandons the frame; outputs fall to 0 on that edge.
    always_comb begin
        tx_state_nxt = TX_IDLE;
        tx_beat_nxt  = '0;
        shadow_nxt   = shadow;
        tx_data_nxt  = '0;
        tx_frame_nxt = 1'b0;
        if (enable) begin
            tx_state_nxt = TX_RUN;
            if (tx_state == TX_IDLE || tx_beat == LAST) begin
                shadow_nxt   = fin_pad;
                tx_frame_nxt = 1'b1;
                tx_data_nxt  = fin_pad[LANES-1:0];
            end else begin
                tx_beat_nxt = tx_beat + 1'b1;
                tx_data_nxt = shadow[int'(tx_beat_nxt) * LANES +: LANES];
            end
        end
    end

    logic [LANES:0]   sync_q [SYNC];
    logic             s_frame;
    logic [LANES-1:0] s_data;

    // Marker and lanes share one synchroniser chain so they stay cycle-aligned.
    always_ff @(posedge UserCLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {rx_frame, rx_data};
            for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s_frame = sync_q[SYNC-1][LANES];
    assign s_data  = sync_q[SYNC-1][LANES-1:0];

    rx_state_t        rx_state, rx_state_nxt;
    logic [BW-1:0]    rx_beat, rx_beat_nxt, idx;
    logic [PW-1:0]    asm_q, asm_nxt;
    logic [WIDTH-1:0] fout_nxt;
    logic             valid_nxt, err;
    logic [7:0]       err_nxt;

    assign rx_locked = (rx_state == RX_LOCK);

    always_ff @(posedge UserCLK or negedge rst_n) begin
        if (!rst_n) begin
            rx_state     <= RX_HUNT;
            rx_beat      <= '0;
            asm_q        <= '0;
            UIO_BOT_FOUT <= '0;
            rx_valid     <= 1'b0;
            err_count    <= '0;
        end else begin
            rx_state     <= rx_state_nxt;
            rx_beat      <= rx_beat_nxt;
            asm_q        <= asm_nxt;
            UIO_BOT_FOUT <= fout_nxt;
            rx_valid     <= valid_nxt;
            err_count    <= err_nxt;
        end
    end

    // A marker always restarts the word at beat 0; a missing marker at beat 0 drops lock.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_beat_nxt  = rx_beat;
        asm_nxt      = asm_q;
        fout_nxt     = UIO_BOT_FOUT;
        valid_nxt    = 1'b0;
        err          = (rx_state == RX_LOCK) && (s_frame != (rx_beat == '0));
        idx          = s_frame ? '0 : rx_beat;
        err_nxt      = (err && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
        if (err && !s_frame) begin
            rx_state_nxt = RX_HUNT;
            rx_beat_nxt  = '0;
        end else if (rx_state == RX_LOCK || s_frame) begin
            rx_state_nxt = RX_LOCK;
            asm_nxt[int'(idx) * LANES +: LANES] = s_data;
            if (idx == LAST) begin
                rx_beat_nxt = '0;
                fout_nxt    = asm_nxt[WIDTH-1:0];
                valid_nxt   = 1'b1;
            end else begin
                rx_beat_nxt = idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_s_term_uio_bot_serdes.sv
// tb_s_term_uio_bot_serdes: directed loopback bench for s_term_uio_bot_serdes.
module tb_s_term_uio_bot_serdes;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [19:0] fin = '0;
    logic [19:0] fout;
    logic [3:0]  tx_data, rx_data, drv_data = '0;
    logic        tx_frame, tx_oe, rx_frame, rx_valid, rx_locked;
    logic [7:0]  err_count;
    logic        loop = 1'b0, flip = 1'b0, drv_frame = 1'b0;
    int          n_vec = 0, n_bad = 0, t = 0;
    logic [19:0] words [5] = '{20'hA5C3F, 20'h12345, 20'hFEDCB, 20'h0F0F0, 20'h5A5A5};
    localparam logic [19:0] W5 = 20'h3C96E, W6 = 20'h81E24, W7 = 20'h47D19, W8 = 20'h0B1D7;

    assign rx_data  = loop ? tx_data : drv_data;
    assign rx_frame = (loop ? tx_frame : drv_frame) ^ flip;

    always #5 clk = ~clk;

    s_term_uio_bot_serdes dut (
        .UserCLK(clk), .rst_n(rst_n), .enable(enable),
        .UIO_BOT_FIN(fin), .UIO_BOT_FOUT(fout),
        .tx_data(tx_data), .tx_frame(tx_frame), .tx_oe(tx_oe),
        .rx_data(rx_data), .rx_frame(rx_frame),
        .rx_valid(rx_valid), .rx_locked(rx_locked), .err_count(err_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0d: got %h, expected %h", tag, t, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        t += n;
    endtask

    initial begin
        enable = 1'b1;
        repeat (4) begin
            fin = 20'($urandom);
            drv_data = 4'($urandom);
            drv_frame = 1'($urandom);
            @(negedge clk);
        end
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_frame", tx_frame, 0);
        chk("rst_tx_oe", tx_oe, 0);
        chk("rst_fout", fout, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_locked", rx_locked, 0);
        chk("rst_err", err_count, 0);
        drv_frame = 1'b0;
        drv_data = '0;
        loop = 1'b1;
        fin = 20'hA5C3F;
        rst_n = 1'b1;
        t = -1;
        step(1);
        chk("lb_frame0", tx_frame, 1);
        chk("lb_data0", tx_data, 4'hF);
        chk("lb_oe", tx_oe, 1);
        step(1);
        chk("lb_data1", tx_data, 4'h3);
        chk("lb_frame1", tx_frame, 0);
        step(3);
        chk("lb_data4", tx_data, 4'hA);
        chk("lb_frame4", tx_frame, 0);
        step(1);
        chk("lb_frame5", tx_frame, 1);
        step(1);
        chk("lb_valid6", rx_valid, 0);
        step(1);
        chk("lb_valid7", rx_valid, 1);
        chk("lb_fout7", fout, 20'hA5C3F);
        chk("lb_locked", rx_locked, 1);
        chk("lb_err", err_count, 0);
        fin = words[1];
        for (int j = 0; j < 4; j++) begin
            step(3);
            chk("b2b_gap", rx_valid, 0);
            if (j < 3) fin = words[j+2];
            step(2);
            chk("b2b_fout", fout, words[j]);
            chk("b2b_valid", rx_valid, 1);
        end
        flip = 1'b1;
        fin = W5;
        step(1);
        flip = 1'b0;
        step(2);
        chk("xtra_err1", err_count, 1);
        chk("xtra_locked", rx_locked, 1);
        step(2);
        chk("xtra_drop_valid", rx_valid, 0);
        chk("xtra_drop_fout", fout, words[3]);
        step(1);
        chk("xtra_realign_err", err_count, 2);
        step(4);
        chk("xtra_next_fout", fout, W5);
        chk("xtra_next_valid", rx_valid, 1);
        fin = W6;
        step(3);
        flip = 1'b1;
        step(1);
        flip = 1'b0;
        fin = W7;
        step(2);
        chk("miss_unlocked", rx_locked, 0);
        chk("miss_err", err_count, 3);
        step(4);
        chk("miss_hunt", rx_locked, 0);
        chk("miss_hold_fout", fout, W5);
        step(1);
        chk("miss_relock", rx_locked, 1);
        step(4);
        chk("miss_next_fout", fout, W7);
        chk("miss_next_valid", rx_valid, 1);
        chk("miss_err_hold", err_count, 3);
        loop = 1'b0;
        drv_frame = 1'b1;
        step(320);
        chk("sat_err", err_count, 8'hFF);
        chk("sat_locked", rx_locked, 1);
        loop = 1'b1;
        drv_frame = 1'b0;
        fin = W8;
        step(20);
        chk("dis_fout_pre", fout, W8);
        step((8 - t % 5) % 5);
        enable = 1'b0;
        step(1);
        chk("dis_tx_data", tx_data, 0);
        chk("dis_tx_frame", tx_frame, 0);
        chk("dis_tx_oe", tx_oe, 0);
        chk("dis_fout", fout, W8);
        step(6);
        chk("dis_fout_hold", fout, W8);
        chk("dis_unlocked", rx_locked, 0);
        chk("dis_err_sat", err_count, 8'hFF);
        enable = 1'b1;
        step(8);
        chk("arst_pre_oe", tx_oe, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_fout", fout, 0);
        chk("arst_err", err_count, 0);
        chk("arst_locked", rx_locked, 0);
        chk("arst_tx_oe", tx_oe, 0);
        chk("arst_tx_frame", tx_frame, 0);
        chk("arst_tx_data", tx_data, 0);
        step(2);
        rst_n = 1'b1;
        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
